// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: phase codes and lamp bundles.
package traffic_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] ST_GA  = 3'd0;
  localparam logic [PHASE_W-1:0] ST_YA  = 3'd1;
  localparam logic [PHASE_W-1:0] ST_RAB = 3'd2;
  localparam logic [PHASE_W-1:0] ST_GB  = 3'd3;
  localparam logic [PHASE_W-1:0] ST_YB  = 3'd4;
  localparam logic [PHASE_W-1:0] ST_RBA = 3'd5;

  typedef struct packed {
    logic ga;
    logic ya;
    logic ra;
    logic gb;
    logic yb;
    logic rb;
  } lamps_t;

  localparam lamps_t LAMPS_GA     = 6'b100_001;
  localparam lamps_t LAMPS_YA     = 6'b010_001;
  localparam lamps_t LAMPS_ALLRED = 6'b001_001;
  localparam lamps_t LAMPS_GB     = 6'b001_100;
  localparam lamps_t LAMPS_YB     = 6'b001_010;

  // Unknown phase codes show all-red, the only safe picture.
  function automatic lamps_t lamps_for(input logic [PHASE_W-1:0] st);
    lamps_t l;
    case (st)
      ST_GA:   l = LAMPS_GA;
      ST_YA:   l = LAMPS_YA;
      ST_RAB:  l = LAMPS_ALLRED;
      ST_GB:   l = LAMPS_GB;
      ST_YB:   l = LAMPS_YB;
      ST_RBA:  l = LAMPS_ALLRED;
      default: l = LAMPS_ALLRED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Phase timer: prescaler producing a one-cycle tick strobe and a saturating
// tick counter, both cleared synchronously whenever the phase changes.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned TW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic          tick,
  output logic [TW-1:0] count
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_r;
  logic [TW-1:0] count_r;

  assign tick  = (presc_r == PW'(TICK_DIV - 1));
  assign count = count_r;

  // Prescaler and saturating tick counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= {PW{1'b0}};
      count_r <= {TW{1'b0}};
    end else if (clr) begin
      presc_r <= {PW{1'b0}};
      count_r <= {TW{1'b0}};
    end else if (tick) begin
      presc_r <= {PW{1'b0}};
      if (count_r != {TW{1'b1}}) begin
        count_r <= count_r + TW'(1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      presc_r <= presc_r + PW'(1);
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-street intersection scheduler: timed green/yellow/all-red phases with
// min/max green, latched pedestrian walk requests and emergency preemption.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 10000,
  parameter int unsigned T_GREEN_MIN = 5,
  parameter int unsigned T_GREEN_MAX = 30,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 4,
  parameter int unsigned TW          = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               Sa,
  input  logic               Sb,
  input  logic               Pa,
  input  logic               Pb,
  input  logic               Ea,
  input  logic               Eb,
  output logic               Ga,
  output logic               Ya,
  output logic               Ra,
  output logic               Gb,
  output logic               Yb,
  output logic               Rb,
  output logic               Wa,
  output logic               Wb,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] state_r;
  logic [PHASE_W-1:0] next_state_s;
  logic               clr_s;
  logic               tick_s;
  logic [TW-1:0]      count_s;
  logic               pend_a_r;
  logic               pend_b_r;
  logic               walk_a_r;
  logic               walk_b_r;
  logic               enter_ga_s;
  logic               enter_gb_s;
  logic               green_min_s;
  logic               green_max_s;
  logic               yellow_done_s;
  logic               allred_done_s;
  logic               walk_done_s;
  lamps_t             lamps_s;
  logic               wa_s;
  logic               wb_s;
  lamps_t             lamps_r;
  logic               wa_r;
  logic               wb_r;
  logic [PHASE_W-1:0] phase_r;

  // Elapsed ticks counted including the tick completing this cycle, so a phase
  // of n ticks changes state exactly n*TICK_DIV cycles after entry.
  function automatic logic reached(input logic [TW-1:0] cnt, input logic tk,
                                   input int unsigned n);
    logic [TW:0] elapsed;
    elapsed = {1'b0, cnt} + {{TW{1'b0}}, tk};
    return elapsed >= (TW + 1)'(n);
  endfunction

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .tick    (tick_s),
    .count   (count_s)
  );

  assign clr_s         = (next_state_s != state_r);
  assign enter_ga_s    = (next_state_s == ST_GA) && (state_r != ST_GA);
  assign enter_gb_s    = (next_state_s == ST_GB) && (state_r != ST_GB);
  assign green_min_s   = reached(count_s, tick_s, T_GREEN_MIN);
  assign green_max_s   = reached(count_s, tick_s, T_GREEN_MAX);
  assign yellow_done_s = reached(count_s, tick_s, T_YELLOW);
  assign allred_done_s = reached(count_s, tick_s, T_ALLRED);
  assign walk_done_s   = reached(count_s, tick_s, T_WALK);

  // Phase state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_GA;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-phase decision; preemption for the other street wins over timing.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_GA: begin
        if (Eb && !Ea) begin
          next_state_s = ST_YA;
        end else if (!Ea && green_min_s && !walk_a_r && (Sb || pend_b_r) &&
                     (!Sa || green_max_s)) begin
          next_state_s = ST_YA;
        end else begin
          next_state_s = ST_GA;
        end
      end
      ST_YA: begin
        if (yellow_done_s) begin
          next_state_s = ST_RAB;
        end else begin
          next_state_s = ST_YA;
        end
      end
      ST_RAB: begin
        if (allred_done_s) begin
          next_state_s = ST_GB;
        end else begin
          next_state_s = ST_RAB;
        end
      end
      ST_GB: begin
        if (Ea && !Eb) begin
          next_state_s = ST_YB;
        end else if (!Eb && green_min_s && !walk_b_r && (Sa || pend_a_r) &&
                     (!Sb || green_max_s)) begin
          next_state_s = ST_YB;
        end else begin
          next_state_s = ST_GB;
        end
      end
      ST_YB: begin
        if (yellow_done_s) begin
          next_state_s = ST_RBA;
        end else begin
          next_state_s = ST_YB;
        end
      end
      ST_RBA: begin
        if (allred_done_s) begin
          next_state_s = ST_GA;
        end else begin
          next_state_s = ST_RBA;
        end
      end
      default: next_state_s = ST_GA;
    endcase
  end

  // Street A request latch and walk timer; a press coinciding with green
  // entry is kept for the following green.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_a_r <= 1'b0;
      walk_a_r <= 1'b0;
    end else if (enter_ga_s) begin
      walk_a_r <= pend_a_r;
      pend_a_r <= Pa;
    end else begin
      pend_a_r <= pend_a_r | Pa;
      if (next_state_s != ST_GA) begin
        walk_a_r <= 1'b0;
      end else if (walk_done_s) begin
        walk_a_r <= 1'b0;
      end else begin
        walk_a_r <= walk_a_r;
      end
    end
  end

  // Street B request latch and walk timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_b_r <= 1'b0;
      walk_b_r <= 1'b0;
    end else if (enter_gb_s) begin
      walk_b_r <= pend_b_r;
      pend_b_r <= Pb;
    end else begin
      pend_b_r <= pend_b_r | Pb;
      if (next_state_s != ST_GB) begin
        walk_b_r <= 1'b0;
      end else if (walk_done_s) begin
        walk_b_r <= 1'b0;
      end else begin
        walk_b_r <= walk_b_r;
      end
    end
  end

  // Moore lamp decode from the current phase.
  always_comb begin
    lamps_s = lamps_for(state_r);
    wa_s    = walk_a_r && (state_r == ST_GA);
    wb_s    = walk_b_r && (state_r == ST_GB);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lamps_r <= LAMPS_GA;
      wa_r    <= 1'b0;
      wb_r    <= 1'b0;
      phase_r <= ST_GA;
    end else begin
      lamps_r <= lamps_s;
      wa_r    <= wa_s;
      wb_r    <= wb_s;
      phase_r <= state_r;
    end
  end

  assign Ga    = lamps_r.ga;
  assign Ya    = lamps_r.ya;
  assign Ra    = lamps_r.ra;
  assign Gb    = lamps_r.gb;
  assign Yb    = lamps_r.yb;
  assign Rb    = lamps_r.rb;
  assign Wa    = wa_r;
  assign Wb    = wb_r;
  assign phase = phase_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: expected phase/lamp segments are queued per
// scenario and compared against run-length segments captured from the outputs.
module tb_intersection_scheduler;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Sa, Sb, Pa, Pb, Ea, Eb;
  logic       Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n),
    .Sa(Sa), .Sb(Sb), .Pa(Pa), .Pb(Pb), .Ea(Ea), .Eb(Eb),
    .Ga(Ga), .Ya(Ya), .Ra(Ra), .Gb(Gb), .Yb(Yb), .Rb(Rb),
    .Wa(Wa), .Wb(Wb), .phase(phase)
  );

  typedef struct packed {
    logic [10:0] pat;
    logic [31:0] len;
  } seg_t;

  // {phase, Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb}
  localparam logic [10:0] P_GA  = {3'd0, 8'b1000_0100};
  localparam logic [10:0] P_GAW = {3'd0, 8'b1000_0110};
  localparam logic [10:0] P_YA  = {3'd1, 8'b0100_0100};
  localparam logic [10:0] P_RAB = {3'd2, 8'b0010_0100};
  localparam logic [10:0] P_GB  = {3'd3, 8'b0011_0000};
  localparam logic [10:0] P_GBW = {3'd3, 8'b0011_0001};
  localparam logic [10:0] P_YB  = {3'd4, 8'b0010_1000};
  localparam logic [10:0] P_RBA = {3'd5, 8'b0010_0100};

  seg_t exp_q[$];
  seg_t obs_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   inv_errs    = 0;

  function automatic seg_t mk(input logic [10:0] p, input int n);
    seg_t s;
    s.pat = p;
    s.len = 32'(n);
    return s;
  endfunction

  // Sample n cycles on the falling edge, recording run-length segments and
  // counting any lamp-invariant violation.
  task automatic capture(input int n);
    logic [10:0] cur;
    logic [10:0] prev;
    int          run;
    prev = 11'h0;
    run  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cur = {phase, Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb};
      if ((int'(Ga) + int'(Ya) + int'(Ra) > 1) || (int'(Gb) + int'(Yb) + int'(Rb) > 1) ||
          ((Ga | Ya) && (Gb | Yb)) || ((Wa | Wb) && (Ya | Yb)) ||
          (Wa && !Ga) || (Wb && !Gb)) begin
        inv_errs++;
      end
      if (run > 0 && cur === prev) begin
        run++;
      end else begin
        if (run > 0) obs_q.push_back(mk(prev, run));
        prev = cur;
        run  = 1;
      end
    end
    if (run > 0) obs_q.push_back(mk(prev, run));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    Sa = 1'b0; Sb = 1'b0; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb} !== 8'b1000_0100) begin
      miscompares++;
      $display("FAIL reset_lamps: observed %b, expected %b", {Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb}, 8'b1000_0100);
    end
    vectors++;
    if (phase !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_phase: observed %0d, expected 0", phase);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_min_green();
    seg_t e, o;
    int   k;
    Sa = 1'b0; Sb = 1'b1; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    exp_q.push_back(mk(P_GA, 20));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GB, 44));
    inv_errs = 0;
    capture(80);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL min_green seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL min_green extra_segments: observed %0d, expected 0", obs_q.size());
    end
    obs_q.delete();
    vectors++;
    if (inv_errs !== 0) begin
      miscompares++;
      $display("FAIL min_green invariants: observed %0d violations, expected 0", inv_errs);
    end
  endtask

  task automatic test_max_green();
    seg_t e, o;
    int   k;
    Sa = 1'b1; Sb = 1'b1; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    exp_q.push_back(mk(P_GA, 120));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GB, 120));
    exp_q.push_back(mk(P_YB, 12));
    exp_q.push_back(mk(P_RBA, 4));
    exp_q.push_back(mk(P_GA, 28));
    inv_errs = 0;
    capture(300);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL max_green seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0 || inv_errs !== 0) begin
      miscompares++;
      $display("FAIL max_green extra/invariants: observed %0d extra, %0d violations, expected 0 and 0", obs_q.size(), inv_errs);
    end
    obs_q.delete();
  endtask

  task automatic test_ped_walk();
    seg_t e, o;
    int   k;
    Sa = 1'b1; Sb = 1'b0; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    exp_q.push_back(mk(P_GA, 120));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GBW, 16));
    exp_q.push_back(mk(P_GB, 4));
    exp_q.push_back(mk(P_YB, 12));
    exp_q.push_back(mk(P_RBA, 4));
    exp_q.push_back(mk(P_GA, 138));
    inv_errs = 0;
    fork
      capture(310);
      begin
        repeat (10) @(posedge clk);
        #1 Pb = 1'b1;
        @(posedge clk);
        #1 Pb = 1'b0;
      end
    join
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL ped_walk seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0 || inv_errs !== 0) begin
      miscompares++;
      $display("FAIL ped_walk extra/invariants: observed %0d extra, %0d violations, expected 0 and 0", obs_q.size(), inv_errs);
    end
    obs_q.delete();
  endtask

  task automatic test_preempt();
    seg_t e, o;
    int   k;
    Sa = 1'b0; Sb = 1'b0; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    exp_q.push_back(mk(P_GA, 4));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GB, 81));
    exp_q.push_back(mk(P_YB, 12));
    exp_q.push_back(mk(P_RBA, 4));
    exp_q.push_back(mk(P_GA, 23));
    inv_errs = 0;
    fork
      capture(140);
      begin
        repeat (3) @(posedge clk);
        #1 Eb = 1'b1;
        repeat (19) @(posedge clk);
        #1 begin Ea = 1'b1; Sa = 1'b1; end
        repeat (78) @(posedge clk);
        #1 Eb = 1'b0;
      end
    join
    Ea = 1'b0; Sa = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL preempt seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0 || inv_errs !== 0) begin
      miscompares++;
      $display("FAIL preempt extra/invariants: observed %0d extra, %0d violations, expected 0 and 0", obs_q.size(), inv_errs);
    end
    obs_q.delete();
  endtask

  task automatic test_walk_relatch();
    seg_t e, o;
    int   k;
    Sa = 1'b0; Sb = 1'b0; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    exp_q.push_back(mk(P_GA, 20));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GBW, 16));
    exp_q.push_back(mk(P_GB, 4));
    exp_q.push_back(mk(P_YB, 12));
    exp_q.push_back(mk(P_RBA, 4));
    exp_q.push_back(mk(P_GAW, 16));
    exp_q.push_back(mk(P_GA, 4));
    exp_q.push_back(mk(P_YA, 12));
    exp_q.push_back(mk(P_RAB, 4));
    exp_q.push_back(mk(P_GBW, 16));
    exp_q.push_back(mk(P_GB, 4));
    exp_q.push_back(mk(P_YB, 12));
    exp_q.push_back(mk(P_RBA, 4));
    exp_q.push_back(mk(P_GAW, 16));
    inv_errs = 0;
    fork
      capture(160);
      begin
        repeat (2) @(posedge clk);
        #1 begin Pa = 1'b1; Pb = 1'b1; end
        @(posedge clk);
        #1 begin Pa = 1'b0; Pb = 1'b0; end
        repeat (77) @(posedge clk);
        #1 begin Pa = 1'b1; Pb = 1'b1; end
        @(posedge clk);
        #1 begin Pa = 1'b0; Pb = 1'b0; end
      end
    join
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL walk_relatch seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0 || inv_errs !== 0) begin
      miscompares++;
      $display("FAIL walk_relatch extra/invariants: observed %0d extra, %0d violations, expected 0 and 0", obs_q.size(), inv_errs);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_yb();
    seg_t e, o;
    int   k;
    Sa = 1'b1; Sb = 1'b1; Pa = 1'b0; Pb = 1'b0; Ea = 1'b0; Eb = 1'b0;
    apply_reset();
    repeat (200) @(posedge clk);
    #1 begin Pa = 1'b1; Pb = 1'b1; end
    @(posedge clk);
    #1 begin Pa = 1'b0; Pb = 1'b0; end
    repeat (59) @(posedge clk);
    #1;
    vectors++;
    if (phase !== 3'd4 || Yb !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_yb_state: observed phase %0d Yb %b, expected phase 4 Yb 1", phase, Yb);
    end
    reset_n = 1'b0;
    Sa = 1'b0; Sb = 1'b0;
    #1;
    vectors++;
    if ({Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb} !== 8'b1000_0100 || phase !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_yb_async_reset: observed lamps %b phase %0d, expected %b phase 0",
               {Ga, Ya, Ra, Gb, Yb, Rb, Wa, Wb}, phase, 8'b1000_0100);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // A surviving pend_b would end this green after the minimum time.
    exp_q.push_back(mk(P_GA, 60));
    inv_errs = 0;
    capture(60);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = mk(11'h7ff, 0);
      vectors++;
      if (o.pat !== e.pat || o.len !== e.len) begin
        miscompares++;
        $display("FAIL reset_mid_yb seg%0d: observed %b x%0d, expected %b x%0d", k, o.pat, o.len, e.pat, e.len);
      end
      k++;
    end
    vectors++;
    if (obs_q.size() !== 0 || inv_errs !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_yb extra/invariants: observed %0d extra, %0d violations, expected 0 and 0", obs_q.size(), inv_errs);
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_min_green();
    test_max_green();
    test_ped_walk();
    test_preempt();
    test_walk_relatch();
    test_reset_mid_yb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
